// File: rtl/vga_frame_scanner.sv
// vga_frame_scanner
// Raster timing generator and pixel fetch path for the VRAM read port.
// Scans a full VGA frame, emits a row-major address stream for the pixels
// that fall inside a centred image window, and turns the returned VRAM byte
// into a grayscale pixel with matching sync and blanking.
// The window is centred in the visible area: X0 = (H_VIS-DIM)/2 and
// Y0 = (V_VIS-DIM)/2, where DIM is selected once per frame.

module vga_frame_scanner #(
    parameter int         H_VIS    = 640,
    parameter int         H_FP     = 16,
    parameter int         H_SYNC   = 96,
    parameter int         H_BP     = 48,
    parameter int         V_VIS    = 480,
    parameter int         V_FP     = 10,
    parameter int         V_SYNC   = 2,
    parameter int         V_BP     = 33,
    parameter int         ORIG_DIM = 400,
    parameter int         ZOOM_DIM = 300,
    parameter int         VRAM_LAT = 1,
    parameter logic [7:0] BORDER   = 8'h00
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_image_select,
    input  logic [7:0]  i_vram_out,
    output logic [31:0] o_gpu_address,
    output logic [7:0]  o_rgb_out,
    output logic        o_hsync,
    output logic        o_vsync,
    output logic        o_blank_n,
    output logic        o_frame_start
);

    localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);

    localparam logic [HW-1:0] H_LAST    = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0] V_LAST    = VW'(V_TOTAL - 1);
    localparam logic [HW-1:0] H_VIS_END = HW'(H_VIS);
    localparam logic [VW-1:0] V_VIS_END = VW'(V_VIS);
    localparam logic [HW-1:0] HS_FIRST  = HW'(H_VIS + H_FP);
    localparam logic [HW-1:0] HS_LAST   = HW'(H_VIS + H_FP + H_SYNC - 1);
    localparam logic [VW-1:0] VS_FIRST  = VW'(V_VIS + V_FP);
    localparam logic [VW-1:0] VS_LAST   = VW'(V_VIS + V_FP + V_SYNC - 1);

    // Window corners; *_LO is inclusive, *_HI is exclusive.
    localparam logic [HW-1:0] OX_LO = HW'((H_VIS - ORIG_DIM) / 2);
    localparam logic [HW-1:0] OX_HI = HW'((H_VIS - ORIG_DIM) / 2 + ORIG_DIM);
    localparam logic [VW-1:0] OY_LO = VW'((V_VIS - ORIG_DIM) / 2);
    localparam logic [VW-1:0] OY_HI = VW'((V_VIS - ORIG_DIM) / 2 + ORIG_DIM);
    localparam logic [HW-1:0] ZX_LO = HW'((H_VIS - ZOOM_DIM) / 2);
    localparam logic [HW-1:0] ZX_HI = HW'((H_VIS - ZOOM_DIM) / 2 + ZOOM_DIM);
    localparam logic [VW-1:0] ZY_LO = VW'((V_VIS - ZOOM_DIM) / 2);
    localparam logic [VW-1:0] ZY_HI = VW'((V_VIS - ZOOM_DIM) / 2 + ZOOM_DIM);

    // Per-pixel control bits that travel alongside the VRAM fetch.
    typedef struct packed {
        logic win;
        logic vis;
        logic hs;
        logic vs;
        logic fs;
    } ctl_t;

    localparam ctl_t CTL_IDLE = '{win: 1'b0, vis: 1'b0, hs: 1'b1, vs: 1'b1, fs: 1'b0};

    logic [HW-1:0] r_h_cnt;
    logic [VW-1:0] r_v_cnt;
    logic          r_sel_q;
    logic [31:0]   r_addr_cnt;
    logic [31:0]   r_gpu_address;
    ctl_t          r_pipe [0:VRAM_LAT];

    logic          w_h_last;
    logic          w_v_last;
    logic          w_frame_origin;
    logic          w_visible;
    logic          w_in_win;
    logic [HW-1:0] w_x_lo;
    logic [HW-1:0] w_x_hi;
    logic [VW-1:0] w_y_lo;
    logic [VW-1:0] w_y_hi;
    logic [31:0]   w_addr_base;
    ctl_t          w_ctl;
    ctl_t          w_tail;

    assign w_h_last       = (r_h_cnt == H_LAST);
    assign w_v_last       = (r_v_cnt == V_LAST);
    assign w_frame_origin = (r_h_cnt == '0) && (r_v_cnt == '0);
    assign w_visible      = (r_h_cnt < H_VIS_END) && (r_v_cnt < V_VIS_END);

    // Raster counters: h wraps at end of line, v advances on every h wrap.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_h_cnt <= '0;
            r_v_cnt <= '0;
        end else if (w_h_last) begin
            r_h_cnt <= '0;
            r_v_cnt <= w_v_last ? '0 : r_v_cnt + VW'(1);
        end else begin
            r_h_cnt <= r_h_cnt + HW'(1);
        end
    end

    // Image selection is frozen for the whole frame, sampled at the origin.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_sel_q <= 1'b0;
        end else if (w_frame_origin) begin
            r_sel_q <= i_image_select;
        end
    end

    // Window bounds for the image currently being scanned.
    always_comb begin
        w_x_lo = OX_LO;
        w_x_hi = OX_HI;
        w_y_lo = OY_LO;
        w_y_hi = OY_HI;
        if (r_sel_q) begin
            w_x_lo = ZX_LO;
            w_x_hi = ZX_HI;
            w_y_lo = ZY_LO;
            w_y_hi = ZY_HI;
        end
    end

    assign w_in_win = (r_h_cnt >= w_x_lo) && (r_h_cnt < w_x_hi) &&
                      (r_v_cnt >= w_y_lo) && (r_v_cnt < w_y_hi);

    // The origin restarts the address count even if it lies inside the window.
    assign w_addr_base = w_frame_origin ? 32'd0 : r_addr_cnt;

    // Row-major address stream: one step per window pixel, held elsewhere.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_addr_cnt    <= 32'd0;
            r_gpu_address <= 32'd0;
        end else if (w_in_win) begin
            r_gpu_address <= w_addr_base;
            r_addr_cnt    <= w_addr_base + 32'd1;
        end else if (w_frame_origin) begin
            r_addr_cnt    <= 32'd0;
        end
    end

    assign o_gpu_address = r_gpu_address;

    // Control bits for the pixel the counters show this cycle.
    always_comb begin
        w_ctl     = CTL_IDLE;
        w_ctl.win = w_in_win;
        w_ctl.vis = w_visible;
        w_ctl.hs  = !((r_h_cnt >= HS_FIRST) && (r_h_cnt <= HS_LAST));
        w_ctl.vs  = !((r_v_cnt >= VS_FIRST) && (r_v_cnt <= VS_LAST));
        w_ctl.fs  = w_frame_origin;
    end

    // Delay control to the cycle the fetched byte is valid at i_vram_out.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            for (int k = 0; k <= VRAM_LAT; k++) begin
                r_pipe[k] <= CTL_IDLE;
            end
        end else begin
            r_pipe[0] <= w_ctl;
            for (int k = 1; k <= VRAM_LAT; k++) begin
                r_pipe[k] <= r_pipe[k-1];
            end
        end
    end

    assign w_tail = r_pipe[VRAM_LAT];

    // Output register: image byte, border colour or black, plus aligned syncs.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_rgb_out     <= 8'h00;
            o_hsync       <= 1'b1;
            o_vsync       <= 1'b1;
            o_blank_n     <= 1'b0;
            o_frame_start <= 1'b0;
        end else begin
            if (w_tail.win) begin
                o_rgb_out <= i_vram_out;
            end else if (w_tail.vis) begin
                o_rgb_out <= BORDER;
            end else begin
                o_rgb_out <= 8'h00;
            end
            o_hsync       <= w_tail.hs;
            o_vsync       <= w_tail.vs;
            o_blank_n     <= w_tail.vis;
            o_frame_start <= w_tail.fs;
        end
    end

endmodule

// File: doc/vga_frame_scanner.md
Name: vga_frame_scanner

Overview:
- Display-side consumer of the interpolation CPU's VRAM read port.
- Generates 640x480@60 VGA timing and a windowed, centred raster address stream (gpu_address).
- Captures the returned vram_out byte and drives grayscale rgb_out with matching hsync/vsync/blank.
- Shows either the 400x400 original or the 300x300 zoomed image; the selection is switched only on frame boundaries.

Parameters:
- H_VIS, 640, visible pixels per line
- H_FP, 16, horizontal front porch
- H_SYNC, 96, hsync pulse width
- H_BP, 48, horizontal back porch
- V_VIS, 480, visible lines
- V_FP, 10, vertical front porch
- V_SYNC, 2, vsync pulse width
- V_BP, 33, vertical back porch
- ORIG_DIM, 400, original image side length (pixels)
- ZOOM_DIM, 300, zoomed image side length (pixels)
- VRAM_LAT, 1, clock cycles from gpu_address to valid vram_out
- BORDER, 8'h00, rgb value for visible pixels outside the image window

Ports:
- clk  in  1  pixel clock (25 MHz nominal); the only clock
- reset  in  1  synchronous, active-high reset
- image_select  in  1  0 = original image, 1 = zoomed image; sampled at frame start
- vram_out  in  8  pixel byte from the CPU VRAM, valid VRAM_LAT cycles after gpu_address
- gpu_address  out  32  VRAM read address, row-major within the selected image
- rgb_out  out  8  grayscale pixel to the DAC
- hsync  out  1  active-low horizontal sync
- vsync  out  1  active-low vertical sync
- blank_n  out  1  1 during the visible region
- frame_start  out  1  one-cycle pulse aligned with output pixel (0,0)

Behaviour:
- Counters
  - h_cnt runs 0..799 and wraps to 0.
  - v_cnt runs 0..524; it increments when h_cnt wraps and wraps to 0 after 524.
  - Visible region: h<640 and v<480.
  - hsync low for h in 656..751; vsync low for v in 490..491.
- Image selection
  - sel_q latches image_select only when h_cnt=0 and v_cnt=0.
  - Changes at any other time take effect at the next frame.
- Window
  - DIM = ORIG_DIM when sel_q=0, ZOOM_DIM when sel_q=1.
  - X0 = (640-DIM)/2, Y0 = (480-DIM)/2. Original: X0=120, Y0=40. Zoomed: X0=170, Y0=90.
  - in_win = X0<=h<X0+DIM and Y0<=v<Y0+DIM.
- Address generation (no multiplier)
  - addr_cnt clears to 0 at h=0, v=0.
  - addr_cnt increments by 1 after each in_win pixel.
  - gpu_address is registered: it equals the address of pixel (h,v) one cycle after the counters show (h,v).
  - Outside the window, gpu_address holds its last value.
  - Final address per frame: 159999 for the original, 89999 for the zoomed image.
- Output pipeline
  - rgb_out registers vram_out when the delayed in_win is 1; BORDER when the delayed visible-but-not-in_win is 1; 0 when blanked.
  - Total latency from counter value to rgb_out is 2+VRAM_LAT cycles (3 by default).
  - hsync, vsync, blank_n, in_win and frame_start pass through an equal-depth shift pipeline, so all outputs stay pixel-aligned.
- Reset values (while reset is high and on the first cycle after it)
  - h_cnt=0, v_cnt=0, addr_cnt=0, sel_q=0, gpu_address=0.
  - rgb_out=0, hsync=1, vsync=1, blank_n=0, frame_start=0.
  - All pipeline stages are cleared to the blanked/inactive state.
- Reset asserted mid-frame: the scan aborts, and the first frame after release starts at (0,0) with sel_q taken from image_select at that moment.
- Simultaneous wrap (h=799, v=524): both counters return to 0 on the same edge.

Test Plan:
- Timing: release reset and run 2 frames. Required: hsync period 800 clk, low for 96 clk; vsync period 420000 clk, low for 1600 clk; blank_n high for 640 clk per visible line.
- Original window: image_select=0, frame 1. Required: first gpu_address change to 0 is driven 1 cycle after h=120, v=40. Address at h=519, v=40 is 399; at h=120, v=41 it is 400; at h=519, v=439 it is 159999.
- Zoomed window: image_select=1 before frame start. Required: window at x 170..469, y 90..389; final address 89999; a VRAM model returning addr[7:0] produces rgb_out==(addr&255) exactly 3 cycles after the counter position.
- Mid-frame select: toggle image_select 0->1 at v=200. Required: the current frame completes as original (last address 159999); the next frame is zoomed.
- Border and blank: BORDER=8'h55. Required: rgb_out=8'h55 at visible pixel (0,0) and at (639,479); rgb_out=0 at h=700.
- Reset mid-operation: assert reset for 3 cycles at h=300, v=100. Required: outputs at reset values during reset; frame_start pulses exactly 3 cycles after release.
